// File: rtl/spi_target.sv
// spi_target: mode-3, MSB-first 16-bit SPI target; decodes {rw, addr[6:0], data[7:0]} into register strobes.
// Latency: SYNC_STAGES+1 cycles pin-to-edge; reg_re/reg_we one cycle after the 8th/16th detected rising edge.
// Backpressure: none; optional SPI_TARGET_BURST_EN turns the post-frame hold into auto-incrementing bursts.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       spi_clk,
  input  logic       reset_n,
  input  logic       SPI_CLK,
  input  logic       SPI_CSN,
  input  logic       SPI_SDI,
  output logic       SPI_SDO,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, HOLD} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, csn_sync_q, sdi_sync_q;
  logic clk_prev_q, clk_s, csn_s, sdi_s, rise, fall;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       loaded_q, loaded_d;
  logic       armed_q, armed_d;
  logic       re_dly_q;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d, reg_re_q, reg_re_d, err_q, err_d;
  logic       sdo_q, sdo_d;
`ifdef SPI_TARGET_BURST_EN
  logic       beat_q, beat_d;
`endif

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign csn_s = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
  assign rise  = clk_s & ~clk_prev_q;
  assign fall  = ~clk_s & clk_prev_q;

  assign SPI_SDO   = sdo_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_err = err_q;
  // armed_q gates busy so a frame already running at reset release never reports as in progress.
  assign busy      = armed_q & ~csn_s;

  // Pin synchronizers; CSN resets to "selected" so only a CSN-high observation arms the FSM after reset.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      csn_sync_q <= '0;
      sdi_sync_q <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], SPI_CSN};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], SPI_SDI};
      clk_prev_q <= clk_s;
    end
  end

  // Frame state, shift registers and registered strobes.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      loaded_q    <= 1'b0;
      armed_q     <= 1'b0;
      re_dly_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      err_q       <= 1'b0;
      sdo_q       <= 1'b1;
`ifdef SPI_TARGET_BURST_EN
      beat_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      loaded_q    <= loaded_d;
      armed_q     <= armed_d;
      re_dly_q    <= reg_re_q;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      err_q       <= err_d;
      sdo_q       <= sdo_d;
`ifdef SPI_TARGET_BURST_EN
      beat_q      <= beat_d;
`endif
    end
  end

  // Next-state: bit counting, command/data decode, read-data shift-out and abort handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    loaded_d    = loaded_q;
    armed_d     = armed_q | csn_s;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    err_d       = 1'b0;
`ifdef SPI_TARGET_BURST_EN
    beat_d      = beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && !csn_s) begin
          state_d  = CMD;
          cnt_d    = '0;
          shift_d  = '0;
          loaded_d = 1'b0;
`ifdef SPI_TARGET_BURST_EN
          beat_d   = 1'b0;
`endif
        end
      end
      CMD, WDATA, RDATA: begin
        if (csn_s) begin
          state_d  = IDLE;
          loaded_d = 1'b0;
`ifdef SPI_TARGET_BURST_EN
          // A completed byte boundary after the first data byte is a clean burst end.
          err_d    = !(beat_q && cnt_q == 4'd8);
`else
          err_d    = 1'b1;
`endif
        end else begin
          // Register file returns data the cycle after reg_re.
          if (state_q == RDATA && re_dly_q) begin
            tx_d     = reg_rdata;
            loaded_d = 1'b1;
          end
          // The falling edge right after rising edge 8 presents bit 7 unshifted.
          if (fall && state_q == RDATA && loaded_q && cnt_q >= 4'd9) begin
            tx_d = {tx_q[6:0], 1'b1};
          end
          if (rise) begin
            shift_d = {shift_q[5:0], sdi_s};
            cnt_d   = cnt_q + 4'd1;
            if (state_q == CMD && cnt_q == 4'd7) begin
              addr_d = {shift_q[5:0], sdi_s};
              if (shift_q[6]) begin
                state_d    = RDATA;
                reg_re_d   = 1'b1;
                reg_addr_d = {shift_q[5:0], sdi_s};
              end else begin
                state_d = WDATA;
              end
            end else if (state_q != CMD && cnt_q == 4'd15) begin
              if (state_q == WDATA) begin
                reg_we_d    = 1'b1;
                reg_addr_d  = addr_q;
                reg_wdata_d = {shift_q, sdi_s};
              end
`ifdef SPI_TARGET_BURST_EN
              cnt_d  = 4'd8;
              addr_d = addr_q + 7'd1;
              beat_d = 1'b1;
              if (state_q == RDATA) begin
                reg_re_d   = 1'b1;
                reg_addr_d = addr_q + 7'd1;
                loaded_d   = 1'b0;
              end
`else
              state_d = HOLD;
`endif
            end
          end
        end
      end
      HOLD: begin
        if (csn_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sdo_d = (state_d == RDATA && loaded_d) ? tx_d[7] : 1'b1;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI secondary (target) endpoint: the responder end of the team's 16-bit, mode-3, MSB-first SPI protocol. It decodes frames driven by the SPI host engine and turns them into single-cycle register-bank strobes. Bit 15 of each frame selects read (1) or write (0), bits 14:8 carry the address, and bits 7:0 carry write data or read-return data. The block sits between the board SPI pins and the local register file, and oversamples all pins on one system clock.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on SPI_CLK, SPI_CSN and SPI_SDI. Must be ≥2.

Ports:
- `spi_clk` in 1: system sampling clock. Frequency must be ≥8× the SPI_CLK frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `SPI_CLK` in 1: serial clock from the host; idles high.
- `SPI_CSN` in 1: chip select, active low.
- `SPI_SDI` in 1: serial data from the host.
- `SPI_SDO` out 1: serial data to the host; high when not driving read data.
- `reg_addr` out 7: register address; valid while `reg_we` or `reg_re` is high.
- `reg_wdata` out 8: write data; valid with `reg_we`.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data; sampled exactly 1 cycle after `reg_re`.
- `busy` out 1: high while a frame is in progress (synchronized CSN low).
- `frame_err` out 1: one-cycle pulse when CSN deasserts before the 16th bit.

Clock and reset: one clock domain (`spi_clk`). Reset is asynchronous and active-low (`reset_n`).

## Operation

- Pins pass through `SYNC_STAGES` flops. Edges are detected on the synchronized SPI_CLK, comparing it against its previous value.
- SDI is sampled on each detected rising edge. SDO is updated on detected falling edges.
- States:
  - IDLE: wait for synchronized CSN = 0, then go to CMD. On entry, clear the bit counter to 0.
  - CMD: shift 8 bits MSB-first into {rw, addr[6:0]}. After the 8th rising edge:
    - rw = 1: pulse `reg_re` with `reg_addr` = addr, go to RDATA.
    - rw = 0: go to WDATA.
  - WDATA: shift 8 bits. After the 16th rising edge, pulse `reg_we` with addr and data, then go to HOLD.
  - RDATA: on the cycle after `reg_re`, latch `reg_rdata` into the TX shift register and drive SDO = bit 7. The falling edge that follows rising edge 8 does not shift. Each falling edge after rising edges 9–15 shifts out the next bit. After the 16th rising edge, go to HOLD.
  - HOLD: ignore all further SPI_CLK edges. SDO = 1. Return to IDLE when CSN = 1.
- CSN rising in CMD, WDATA or RDATA:
  - Go to IDLE and pulse `frame_err`.
  - Drive SDO = 1.
  - Suppress `reg_we`; a `reg_re` already issued stands.
- CSN rising in HOLD: go to IDLE with no error.
- SDO = 1 in every state except RDATA after the read data is latched.
- Address arithmetic is 7-bit and wraps (0x7F + 1 = 0x00).

## Timing

- Reset values:
  - SPI_SDO = 1.
  - `reg_we` = `reg_re` = `frame_err` = `busy` = 0.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - State = IDLE. Shift registers and counter = 0.
- Pin-to-detect latency: `SYNC_STAGES` + 1 cycles.
- `reg_re` asserts 1 cycle after the 8th rising edge is detected. `reg_rdata` is captured on the next cycle.
- `reg_we` asserts 1 cycle after the 16th rising edge is detected.
- All strobes are exactly 1 cycle wide and never overlap.
- `busy` follows synchronized CSN with no extra delay.
- Reset asserted mid-frame aborts immediately. After release, the block waits in IDLE for a fresh CSN falling edge; any frame whose CSN is already low at release is ignored until CSN goes high.
- Back-to-back frames: CSN high for ≥`SYNC_STAGES` + 2 cycles is recognized as a frame boundary.

## Configuration

- `SPI_TARGET_BURST_EN` defined:
  - HOLD is replaced by burst continuation while CSN stays low.
  - Write frames: each further 8 bits produce another `reg_we` at addr+1 (wrapping).
  - Read frames: at the 16th rising edge, issue `reg_re` at addr+1 and shift that byte out on the next 8 edges; repeat for every further 8 bits.
  - Ending CSN on a byte boundary is not an error. Ending it mid-byte pulses `frame_err` and drops only the partial byte.
- `SPI_TARGET_BURST_EN` undefined: behaviour exactly as described above; bits beyond 16 are ignored.

## Test plan

- Write: frame 0x12A5 → exactly one `reg_we`, `reg_addr` = 0x12, `reg_wdata` = 0xA5; no `reg_re`; `frame_err` = 0.
- Read: frame 0x8F00 with `reg_rdata` = 0x3C → one `reg_re` at `reg_addr` = 0x0F; host captures 0x3C on bits 7–0; SDO = 1 before and after; no `reg_we`.
- Abort: write frame cut by CSN high after 11 bits → no `reg_we`, one `frame_err` pulse; the next full frame 0x0155 writes 0x55 to address 0x01.
- Reset: `reset_n` pulsed low during bit 12 of a write → outputs return to reset values, no `reg_we`; the next frame decodes correctly.
- Burst, 24 bits 0x7F1122 with CSN held low: with the macro → writes 0x11 to address 0x7F, then 0x22 to address 0x00; without the macro → a single write of 0x11 to address 0x7F.
- Ratio: SPI_CLK = `spi_clk`/8, two back-to-back read frames → both bytes returned correctly with no missed edges.
